serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle two's-complement subtractor: computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the ripple full-adder datapath: a small-area subtract path for the ALU.
- Produces ALU flags (borrow, zero, signed overflow).
- Uses a start/busy/done handshake toward the ALU control sequencer.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 2 to 64)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when the block is not busy
a  input  WIDTH  minuend, captured on the accepted start edge
b  input  WIDTH  subtrahend, captured on the accepted start edge
busy  output  1  high while the subtraction is in progress
done  output  1  single-cycle pulse marking that the result and flags are valid
diff  output  WIDTH  a - b modulo 2^WIDTH
bout  output  1  final borrow; 1 when a < b as unsigned values
zero  output  1  1 when diff == 0
ovf  output  1  signed overflow of a - b

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asynchronous, whenever rst_n = 0):
  - State goes to IDLE.
  - busy, done, bout, zero, ovf = 0; diff = 0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
  - Reset asserted mid-operation aborts it, and no done pulse follows.
- FSM states: IDLE, SHIFT, FIN.
- IDLE:
  - On a rising edge with start = 1: latch a into ra and b into rb, clear the borrow flip-flop, set count = 0, enter SHIFT.
  - busy goes high in the cycle after that edge.
- SHIFT, each edge:
  - d = ra[0] ^ rb[0] ^ br
  - br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - ra and rb shift right by 1.
  - d enters the MSB of the result register rr, which shifts right.
  - count increments.
  - After the edge where count reaches WIDTH-1 (the WIDTH-th bit), go to FIN.
- FIN, one cycle:
  - Registered outputs update on the edge entering FIN:
    - diff = rr
    - bout = final br
    - zero = (rr == 0)
    - ovf = (a_msb != b_msb) && (rr_msb != a_msb), using the latched operand MSBs.
  - done = 1 and busy = 0 in the FIN cycle.
  - Next edge returns to IDLE and done drops.
- Latency: start accepted at edge 0; done is high during the cycle following edge WIDTH, i.e. WIDTH cycles after acceptance.
- busy is high for exactly WIDTH cycles per operation.
- Results hold:
  - diff, bout, zero and ovf hold their values after done until the next operation's FIN edge.
  - They do not change during SHIFT.
- start handling:
  - start while busy = 1 is ignored (not queued).
  - start = 1 during the FIN cycle is accepted on the edge leaving FIN: go straight to SHIFT and capture new operands, giving back-to-back operation.
  - start held high continuously produces one operation every WIDTH+1 cycles.
- Operand changes on a and b after acceptance have no effect.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - bout is the unsigned borrow, equal to NOT of the adder carry-out for a + ~b + 1.
- Boundary cases:
  - a = b gives diff 0, zero 1, bout 0.
  - 0 - 1 gives all ones, bout 1.
  - Most-negative minus 1 gives ovf 1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy high 8 cycles; done pulse during the cycle after edge 8; diff=0x02, bout=0, zero=0, ovf=0.
- WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, bout=1, zero=0, ovf=0; a=0x00, b=0x01 -> diff=0xFF, bout=1.
- WIDTH=8, a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0; a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- WIDTH=8, a=0x5A, b=0x5A -> diff=0x00, zero=1, bout=0, ovf=0.
- Start re-pulsed with a=0x11 at cycle 3 of a busy operation -> ignored, original result is produced; start held high through FIN -> next operation begins with no idle cycle and done recurs every 9 cycles.
- rst_n pulled low at cycle 4 of SHIFT -> all outputs 0 immediately (asynchronously); no done pulse; a new start after release gives a correct result.
- Random 32-bit operands (WIDTH=32, 1000 vectors) -> diff, bout, zero and ovf match a reference model; done arrives exactly 32 cycles after acceptance.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow flop
// produce a - b LSB first, with borrow/zero/overflow flags and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_rr_next;
    logic             w_accept;
    logic             w_last;

    // Full-subtractor cell and control decodes
    always_comb begin
        w_d       = fs_diff(r_ra[0], r_rb[0], r_br);
        w_br_next = fs_borrow(r_ra[0], r_rb[0], r_br);
        w_rr_next = {w_d, r_rr[WIDTH-1:1]};
        w_last    = (r_cnt == CNT_LAST);
        if ((r_state == IDLE) || (r_state == FIN)) begin
            w_accept = start;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = FIN;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            FIN: begin
                if (start) begin
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and serial shift datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_rr    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    if (w_accept) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_rr    <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
                    r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
                    r_rr  <= w_rr_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Handshake and result registers; results load only on the edge into FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == SHIFT);
            r_done <= (w_state_next == FIN);
            if ((r_state == SHIFT) && w_last) begin
                r_diff <= w_rr_next;
                r_bout <= w_br_next;
                r_zero <= (w_rr_next == '0);
                r_ovf  <= (r_a_msb != r_b_msb) && (w_rr_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed cases and
// a 32-bit instance for random vectors checked against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8;
    logic [7:0] a8, b8, diff8;
    logic       busy8, done8, bout8, zero8, ovf8;

    logic        start32;
    logic [31:0] a32, b32, diff32;
    logic        busy32, done32, bout32, zero32, ovf32;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .zero(zero32), .ovf(ovf32)
    );

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // 8-bit monitor: scoreboard pop on done, latency, busy length and result hold
    initial begin : mon8
        int          busy_cnt8;
        logic        prev_done8;
        logic [10:0] held8;
        exp_t        e;
        busy_cnt8  = 0;
        prev_done8 = 1'b0;
        held8      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt8  = 0;
                prev_done8 = 1'b0;
                held8      = '0;
            end else begin
                if (busy8) begin
                    busy_cnt8++;
                    check_eq("hold8", {bout8, zero8, ovf8, diff8}, held8);
                end
                if (done8) begin
                    check_eq("pending8", (q8.size() != 0), 1'b1);
                    if (q8.size() != 0) begin
                        e = q8.pop_front();
                        check_eq("diff8", diff8, e.d);
                        check_eq("bout8", bout8, e.bo);
                        check_eq("zero8", zero8, e.z);
                        check_eq("ovf8", ovf8, e.ov);
                        check_eq("latency8", cyc - e.acc, 8);
                        check_eq("busy_len8", busy_cnt8, 8);
                        check_eq("busy_in_fin8", busy8, 1'b0);
                        check_eq("done_pulse8", prev_done8, 1'b0);
                        held8 = {e.bo, e.z, e.ov, e.d[7:0]};
                    end
                    busy_cnt8 = 0;
                end
                prev_done8 = done8;
            end
        end
    end

    // 32-bit monitor
    initial begin : mon32
        int   busy_cnt32;
        exp_t e;
        busy_cnt32 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt32 = 0;
            end else begin
                if (busy32) busy_cnt32++;
                if (done32) begin
                    check_eq("pending32", (q32.size() != 0), 1'b1);
                    if (q32.size() != 0) begin
                        e = q32.pop_front();
                        check_eq("diff32", diff32, e.d);
                        check_eq("bout32", bout32, e.bo);
                        check_eq("zero32", zero32, e.z);
                        check_eq("ovf32", ovf32, e.ov);
                        check_eq("latency32", cyc - e.acc, 32);
                        check_eq("busy_len32", busy_cnt32, 32);
                    end
                    busy_cnt32 = 0;
                end
            end
        end
    end

    task automatic push8(input logic [7:0] d, input logic bo, input logic z, input logic ov);
        exp_t e;
        e.d = 64'(d); e.bo = bo; e.z = z; e.ov = ov; e.acc = cyc + 1;
        q8.push_back(e);
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 200; i++) begin
            if (q8.size() == 0) break;
            @(negedge clk); #1;
        end
        check_eq("timeout8", q8.size(), 0);
        q8.delete();
    endtask

    task automatic wait_idle32();
        for (int i = 0; i < 200; i++) begin
            if (q32.size() == 0) break;
            @(negedge clk); #1;
        end
        check_eq("timeout32", q32.size(), 0);
        q32.delete();
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic bo, input logic z, input logic ov);
        a8 = a; b8 = b; start8 = 1'b1;
        push8(d, bo, z, ov);
        @(negedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        wait_idle8();
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] d;
        d     = a - b;
        e.d   = 64'(d);
        e.bo  = (a < b);
        e.z   = (d == 32'd0);
        e.ov  = (a[31] != b[31]) && (d[31] != a[31]);
        e.acc = cyc + 1;
        a32 = a; b32 = b; start32 = 1'b1;
        q32.push_back(e);
        @(negedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
        wait_idle32();
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy8", busy8, 1'b0);
        check_eq("rst_done8", done8, 1'b0);
        check_eq("rst_diff8", diff8, 8'h00);
        check_eq("rst_flags8", {bout8, zero8, ovf8}, 3'b000);
        check_eq("rst_busy32", busy32, 1'b0);
        check_eq("rst_diff32", diff32, 32'h0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
        op8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0);

        // start re-pulsed with new operands in the third busy cycle must be ignored
        a8 = 8'h40; b8 = 8'h10; start8 = 1'b1;
        push8(8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        a8 = 8'h11; start8 = 1'b1;
        @(negedge clk); #1;
        start8 = 1'b0;
        wait_idle8();
        repeat (3) begin @(negedge clk); #1; end

        // start held high: back-to-back operations every 9 cycles
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        push8(8'hF0, 1'b1, 1'b0, 1'b0);
        repeat (9) @(negedge clk); #1;
        a8 = 8'h33; b8 = 8'h33;
        push8(8'h00, 1'b0, 1'b1, 1'b0);
        repeat (9) @(negedge clk); #1;
        a8 = 8'h81; b8 = 8'h02;
        push8(8'h7F, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        start8 = 1'b0;
        wait_idle8();

        // asynchronous reset in the fourth SHIFT cycle aborts the operation
        a8 = 8'h22; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy8", busy8, 1'b0);
        check_eq("abort_done8", done8, 1'b0);
        check_eq("abort_diff8", diff8, 8'h00);
        check_eq("abort_flags8", {bout8, zero8, ovf8}, 3'b000);
        repeat (2) @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); #1; end
        op8(8'h64, 8'h32, 8'h32, 1'b0, 1'b0, 1'b0);

        op32(32'h1234_5678, 32'h1234_5678);
        op32(32'h0000_0000, 32'h0000_0001);
        op32(32'h8000_0000, 32'h0000_0001);
        op32(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 1000; i++) begin
            op32($urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
